// File: rtl/crc_bus_master.sv
// Bus initiator that programs the CRC peripheral, streams N words and reads back the checksum.
// Optional stall timeout: define CRC_MASTER_TIMEOUT_EN.
module crc_bus_master #(
  parameter int unsigned CNT_W       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h4003_2000,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      cfg_ctrl,
  input  logic [31:0]      cfg_poly,
  input  logic [31:0]      cfg_seed,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      result,
  output logic             Sel,
  output logic             RW,
  output logic [31:0]      addr,
  output logic [31:0]      data_wr,
  input  logic [31:0]      data_rd
);

  localparam logic [31:0] A_DATA = BASE_ADDR;
  localparam logic [31:0] A_POLY = BASE_ADDR + 32'd4;
  localparam logic [31:0] A_CTRL = BASE_ADDR + 32'd8;
  localparam logic [31:0] WAS    = 32'h0200_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_CTRL_SEED,
    S_WR_SEED,
    S_WR_POLY,
    S_WR_CTRL_RUN,
    S_STREAM,
    S_READ,
    S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [31:0]      ctrl_q, poly_q, seed_q;
  logic [31:0]      result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             take;
  logic             stall_hit;

  assign take = (state == S_STREAM) && in_valid;

`ifdef CRC_MASTER_TIMEOUT_EN
  localparam int unsigned ST_W = $clog2(TIMEOUT_CYC + 1);

  logic [ST_W-1:0] stall_q;
  logic            err_q;

  assign stall_hit = (state == S_STREAM) && !in_valid &&
                     (stall_q == ST_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state != S_STREAM || take)
        stall_q <= '0;
      else
        stall_q <= stall_q + 1'b1;
      if (stall_hit)
        err_q <= 1'b1;
      else if (state == S_DONE)
        err_q <= 1'b0;
    end
  end

  assign err = (state == S_DONE) && err_q;
`else
  assign stall_hit = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:         if (start) state_nx = S_WR_CTRL_SEED;
      S_WR_CTRL_SEED: state_nx = S_WR_SEED;
      S_WR_SEED:      state_nx = S_WR_POLY;
      S_WR_POLY:      state_nx = S_WR_CTRL_RUN;
      S_WR_CTRL_RUN:  state_nx = (cnt_q == '0) ? S_READ : S_STREAM;
      S_STREAM: begin
        if (take && cnt_q == CNT_W'(1))
          state_nx = S_READ;
        else if (stall_hit)
          state_nx = S_DONE;
      end
      S_READ:         state_nx = S_DONE;
      S_DONE:         state_nx = S_IDLE;
      default:        state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    Sel     = 1'b0;
    RW      = 1'b0;
    addr    = '0;
    data_wr = '0;
    unique case (state)
      S_WR_CTRL_SEED: begin
        Sel = 1'b1; RW = 1'b1;
        addr = A_CTRL; data_wr = ctrl_q | WAS;
      end
      S_WR_SEED: begin
        Sel = 1'b1; RW = 1'b1;
        addr = A_DATA; data_wr = seed_q;
      end
      S_WR_POLY: begin
        Sel = 1'b1; RW = 1'b1;
        addr = A_POLY; data_wr = poly_q;
      end
      S_WR_CTRL_RUN: begin
        Sel = 1'b1; RW = 1'b1;
        addr = A_CTRL; data_wr = ctrl_q & ~WAS;
      end
      S_STREAM: begin
        if (in_valid) begin
          Sel = 1'b1; RW = 1'b1;
          addr = A_DATA; data_wr = in_data;
        end
      end
      S_READ: begin
        Sel = 1'b1;
        addr = A_DATA;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      ctrl_q   <= '0;
      poly_q   <= '0;
      seed_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        ctrl_q <= cfg_ctrl;
        poly_q <= cfg_poly;
        seed_q <= cfg_seed;
        cnt_q  <= cfg_len;
      end else if (take) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (state == S_READ)
        result_q <= data_rd;
    end
  end

  assign in_ready = (state == S_STREAM);
  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign done     = (state == S_DONE);
  assign result   = result_q;

endmodule

// File: tb/tb_crc_bus_master.sv
// Randomised bench for crc_bus_master with a register-level CRC responder
// and a transaction-level model of the expected bus trace.
module tb_crc_bus_master;

  localparam logic [31:0] BASE = 32'h4003_2000;
  localparam logic [31:0] WASB = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] cfg_ctrl, cfg_poly, cfg_seed;
  logic [15:0] cfg_len;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready, busy, done, err;
  logic [31:0] result;
  logic        Sel, RW;
  logic [31:0] addr, data_wr, data_rd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  crc_bus_master #(
    .CNT_W(16), .BASE_ADDR(BASE), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_ctrl(cfg_ctrl), .cfg_poly(cfg_poly),
    .cfg_seed(cfg_seed), .cfg_len(cfg_len),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .busy(busy), .done(done),
    .err(err), .result(result), .Sel(Sel), .RW(RW),
    .addr(addr), .data_wr(data_wr), .data_rd(data_rd)
  );

  function automatic logic [31:0] crc_step(
    input logic [31:0] c, input logic [31:0] d,
    input logic [31:0] p);
    logic [31:0] r;
    r = c ^ d;
    for (int b = 0; b < 32; b++)
      r = r[31] ? ((r << 1) ^ p) : (r << 1);
    return r;
  endfunction

  // responder: CTRL/GPOLY/DATA registers, MSB-first CRC-32 on data writes
  logic [31:0] rsp_ctrl = '0, rsp_poly = '0, rsp_crc = '0;
  logic        fixed_en = 1'b0;

  assign data_rd = fixed_en ? 32'h1234_5678 : rsp_crc;

  always @(posedge clk) begin
    if (Sel && RW) begin
      if (addr == BASE + 32'd8) rsp_ctrl <= data_wr;
      else if (addr == BASE + 32'd4) rsp_poly <= data_wr;
      else if (addr == BASE) begin
        if (rsp_ctrl[25]) rsp_crc <= data_wr;
        else rsp_crc <= crc_step(rsp_crc, data_wr, rsp_poly);
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  logic [31:0] ex_a[$], ex_d[$], ob_a[$], ob_d[$];
  bit          ex_w[$], ob_w[$];

  task automatic push_ex(input logic [31:0] a, input bit w,
                         input logic [31:0] d);
    ex_a.push_back(a); ex_w.push_back(w); ex_d.push_back(d);
  endtask

  task automatic cmp_trace(input string tag);
    chk({tag, "_len"}, ob_a.size(), ex_a.size());
    for (int i = 0; i < ob_a.size() && i < ex_a.size(); i++) begin
      chk($sformatf("%s_a%0d", tag, i), ob_a[i], ex_a[i]);
      chk($sformatf("%s_w%0d", tag, i), 32'(ob_w[i]), 32'(ex_w[i]));
      if (ex_w[i])
        chk($sformatf("%s_d%0d", tag, i), ob_d[i], ex_d[i]);
    end
  endtask

  task automatic sample(inout int viol);
    if (Sel) begin
      ob_a.push_back(addr); ob_w.push_back(RW);
      ob_d.push_back(data_wr);
    end else if (RW || addr != 0 || data_wr != 0) begin
      viol++;
    end
  endtask

  // vmode: 0 steady, 1 toggle starting with a gap, 2 random
  task automatic run_job(input string tag,
                         input logic [31:0] ctrl,
                         input logic [31:0] poly,
                         input logic [31:0] seed,
                         input int n, input int vmode,
                         input int restart, input bit fixed);
    logic [31:0] words[$];
    bit          vp[$];
    logic [31:0] exp_res;
    int t, c, done_exp, got, p, viol;
    ex_a.delete(); ex_w.delete(); ex_d.delete();
    ob_a.delete(); ob_w.delete(); ob_d.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
    for (int i = 0; i < 4 * n + 8; i++) begin
      if (vmode == 0) vp.push_back(1'b1);
      else if (vmode == 1) vp.push_back(i % 2 == 1);
      else vp.push_back(i >= 3 * n ? 1'b1 : ($urandom_range(0, 2) != 0));
    end
    push_ex(BASE + 32'd8, 1'b1, ctrl | WASB);
    push_ex(BASE, 1'b1, seed);
    push_ex(BASE + 32'd4, 1'b1, poly);
    push_ex(BASE + 32'd8, 1'b1, ctrl & ~WASB);
    exp_res = seed;
    foreach (words[i]) begin
      push_ex(BASE, 1'b1, words[i]);
      exp_res = crc_step(exp_res, words[i], poly);
    end
    push_ex(BASE, 1'b0, 32'h0);
    if (fixed) exp_res = 32'h1234_5678;
    t = 5; c = 0;
    while (c < n) begin
      if (vp[t - 5]) c++;
      t++;
    end
    done_exp = t + 1;

    fixed_en = fixed;
    @(negedge clk);
    cfg_ctrl = ctrl; cfg_poly = poly; cfg_seed = seed;
    cfg_len = 16'(n); start = 1'b1;
    got = -1; p = 0; viol = 0;
    for (int k = 1; k < 40 + 8 * n; k++) begin
      @(negedge clk);
      start = (k == restart);
      if (k == restart || k == 2) begin
        cfg_seed = ~seed; cfg_poly = $urandom;
        cfg_ctrl = $urandom; cfg_len = 16'(n + 3);
      end
      in_valid = (k >= 5) && (p < n) && vp[k - 5];
      in_data  = in_valid ? words[p] : $urandom;
      #1;
      if (k == 1) chk({tag, "_busy1"}, 32'(busy), 32'd1);
      sample(viol);
      if (in_valid && in_ready) p++;
      if (done) begin
        got = k;
        chk({tag, "_busy_dn"}, 32'(busy), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_res"}, result, exp_res);
        break;
      end
    end
    in_valid = 1'b0; start = 1'b0;
    chk({tag, "_done_cyc"}, got, done_exp);
    chk({tag, "_idle_bus"}, viol, 0);
    cmp_trace(tag);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_res_hold"}, result, exp_res);
  endtask

  initial begin
    int viol;
    bit saw_done;
    logic [31:0] prev;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    cfg_ctrl = '0; cfg_poly = '0; cfg_seed = '0; cfg_len = '0;
    repeat (2) @(negedge clk);
    chk("rst_out", {busy, done, err, in_ready, Sel, RW}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_dwr", data_wr, 32'd0);
    chk("rst_res", result, 32'd0);
    rst = 1'b1;

    run_job("t1", 32'h0, 32'h04C1_1DB7, 32'hFFFF_FFFF, 0, 0, 0, 1'b1);
    run_job("t2", 32'h0100_0000, 32'h04C1_1DB7, 32'hFFFF_FFFF,
            3, 0, 0, 1'b0);
    run_job("t3", $urandom, $urandom, $urandom, 4, 1, 0, 1'b0);
    run_job("t4", 32'h0100_0000, 32'h04C1_1DB7, 32'h1357_9BDF,
            3, 0, 3, 1'b0);
    for (int j = 0; j < 6; j++)
      run_job($sformatf("r%0d", j), $urandom, $urandom, $urandom,
              $urandom_range(0, 12), 2, 0, 1'b0);

    // reset in the middle of the stream
    @(negedge clk);
    cfg_len = 16'd5; cfg_seed = $urandom; start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      in_valid = (k >= 5); in_data = $urandom;
    end
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_out", {busy, done, err, in_ready, Sel, RW}, 32'd0);
    chk("t5_rst_bus", addr | data_wr, 32'd0);
    chk("t5_rst_res", result, 32'd0);
    in_valid = 1'b0;
    saw_done = 1'b0;
    repeat (3) @(negedge clk) saw_done |= done;
    rst = 1'b1;
    repeat (12) @(negedge clk) saw_done |= done;
    chk("t5_no_done", 32'(saw_done), 32'd0);
    run_job("t5b", $urandom, $urandom, $urandom, 3, 0, 0, 1'b0);

`ifdef CRC_MASTER_TIMEOUT_EN
    prev = result;
    ob_a.delete(); ob_w.delete(); ob_d.delete();
    viol = 0;
    @(negedge clk);
    cfg_len = 16'd2; start = 1'b1;
    saw_done = 1'b0;
    for (int k = 1; k < 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      in_valid = (k == 5); in_data = $urandom;
      #1;
      sample(viol);
      if (done) begin
        saw_done = 1'b1;
        chk("t6_cyc", k, 14);
        chk("t6_err", 32'(err), 32'd1);
        chk("t6_res", result, prev);
        break;
      end
    end
    in_valid = 1'b0;
    chk("t6_done", 32'(saw_done), 32'd1);
    chk("t6_bus_cnt", ob_a.size(), 5);
    chk("t6_no_read", ob_w.size() == 5 ? 32'(ob_w[4]) : 32'd0, 32'd1);
`else
    viol = 0; prev = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
